// File: rtl/ysyx_22041412_pkg.sv
// Shared decode definitions for the ysyx_22041412 IDU: opcodes, operand-select
// and mode encodings, and the decoded-instruction bundle.
package ysyx_22041412_pkg;

   // The bundle always carries a 64-bit immediate; narrower datapaths truncate it.
   localparam int IMM_W = 64;

   localparam logic [6:0] OP_LUI    = 7'b0110111;
   localparam logic [6:0] OP_AUIPC  = 7'b0010111;
   localparam logic [6:0] OP_JAL    = 7'b1101111;
   localparam logic [6:0] OP_JALR   = 7'b1100111;
   localparam logic [6:0] OP_BRANCH = 7'b1100011;
   localparam logic [6:0] OP_LOAD   = 7'b0000011;
   localparam logic [6:0] OP_STORE  = 7'b0100011;
   localparam logic [6:0] OP_IMM    = 7'b0010011;
   localparam logic [6:0] OP_IMM32  = 7'b0011011;
   localparam logic [6:0] OP_REG    = 7'b0110011;
   localparam logic [6:0] OP_REG32  = 7'b0111011;
   localparam logic [6:0] OP_FENCE  = 7'b0001111;
   localparam logic [6:0] OP_SYSTEM = 7'b1110011;

   typedef enum logic [1:0] {V1_RSA = 2'd0, V1_PC  = 2'd1, V1_ZIM = 2'd2} v1type_e;
   typedef enum logic [1:0] {V2_RSB = 2'd0, V2_IMM = 2'd1} v2type_e;
   typedef enum logic [1:0] {MEM_IDLE = 2'd0, MEM_LOAD = 2'd1, MEM_STORE = 2'd2} mem_mode_e;
   typedef enum logic [1:0] {JMP_IDLE = 2'd0, JMP_JAL = 2'd1, JMP_JALR = 2'd2, JMP_B = 2'd3} jump_mode_e;

   typedef struct packed {
      logic [6:0]       opcode;
      logic [2:0]       func3;
      logic             func7;
      logic [4:0]       rs1;
      logic [4:0]       rs2;
      logic [4:0]       rd;
      logic [IMM_W-1:0] imm;
      v1type_e          v1type;
      v2type_e          v2type;
      logic             mul_en;
      mem_mode_e        mem_mode;
      jump_mode_e       jump_mode;
      logic             illegal;
   } dec_t;

endpackage

// File: rtl/ysyx_22041412_idu_dec.sv
// Combinational RV64I instruction decoder with redirect-candidate detection.
// YSYX_22041412_MULDIV_EN enables decoding of M-extension R-type operations.
module ysyx_22041412_idu_dec
   import ysyx_22041412_pkg::*;
#(
   parameter int PREDICT_B = 1
) (
   input  logic [31:0] instr,
   output dec_t        dec,
   output logic        redir_cand
);

   logic [31:0] imm32;

   always_comb begin
      // NOTE: every output gets a default before the case so no latch is inferred.
      dec           = '0;
      dec.opcode    = instr[6:0];
      dec.func3     = instr[14:12];
      dec.func7     = instr[30];
      dec.rs1       = instr[19:15];
      dec.rs2       = instr[24:20];
      dec.rd        = instr[11:7];
      dec.v1type    = V1_RSA;
      dec.v2type    = V2_RSB;
      dec.mem_mode  = MEM_IDLE;
      dec.jump_mode = JMP_IDLE;
      imm32         = '0;
      redir_cand    = 1'b0;

      case (instr[6:0])
         OP_LUI, OP_AUIPC: begin
            dec.rs1    = '0;
            dec.rs2    = '0;
            imm32      = {instr[31:12], 12'b0};
            dec.v1type = (instr[6:0] == OP_AUIPC) ? V1_PC : V1_RSA;
            dec.v2type = V2_IMM;
         end
         OP_JAL: begin
            dec.rs1       = '0;
            dec.rs2       = '0;
            imm32         = {{11{instr[31]}}, instr[31], instr[19:12], instr[20], instr[30:21], 1'b0};
            dec.v1type    = V1_PC;
            dec.v2type    = V2_IMM;
            dec.jump_mode = JMP_JAL;
         end
         OP_BRANCH: begin
            dec.rd        = '0;
            imm32         = {{19{instr[31]}}, instr[31], instr[7], instr[30:25], instr[11:8], 1'b0};
            dec.jump_mode = JMP_B;
         end
         OP_STORE: begin
            dec.rd       = '0;
            imm32        = {{20{instr[31]}}, instr[31:25], instr[11:7]};
            dec.v2type   = V2_IMM;
            dec.mem_mode = MEM_STORE;
         end
         OP_JALR, OP_LOAD, OP_IMM, OP_IMM32, OP_FENCE, OP_SYSTEM: begin
            dec.rs2    = '0;
            imm32      = {{20{instr[31]}}, instr[31:20]};
            dec.v2type = V2_IMM;
            if (instr[6:0] == OP_JALR) dec.jump_mode = JMP_JALR;
            if (instr[6:0] == OP_LOAD) dec.mem_mode  = MEM_LOAD;
            // Immediate-form Zicsr ops take rs1 as a zero-extended 5-bit immediate.
            if (instr[6:0] == OP_SYSTEM && instr[14] && instr[13:12] != 2'b00)
               dec.v1type = V1_ZIM;
         end
         OP_REG, OP_REG32: begin
            if (instr[25]) begin
`ifdef YSYX_22041412_MULDIV_EN
               dec.mul_en  = 1'b1;
`else
               dec.illegal = 1'b1;
`endif
            end
         end
         default: dec.illegal = 1'b1;
      endcase

      // Illegal encodings still flow, but must not write a register or touch memory.
      if (dec.illegal) begin
         dec.rs1       = '0;
         dec.rs2       = '0;
         dec.rd        = '0;
         dec.v1type    = V1_RSA;
         dec.v2type    = V2_RSB;
         dec.mem_mode  = MEM_IDLE;
         dec.jump_mode = JMP_IDLE;
         imm32         = '0;
      end

      dec.imm    = IMM_W'($signed(imm32));
      redir_cand = (dec.jump_mode == JMP_JAL) ||
                   ((dec.jump_mode == JMP_B) && (PREDICT_B != 0) && imm32[31]);
   end

endmodule

// File: rtl/ysyx_22041412_idu.sv
// ysyx_22041412 instruction-decode stage: registered decode output behind a
// valid/ready handshake with one skid entry, plus an early front-end redirect.
module ysyx_22041412_idu
   import ysyx_22041412_pkg::*;
#(
   parameter int XLEN      = 64,
   parameter int PCW       = 32,
   parameter int PREDICT_B = 1
) (
   input  logic            clk,
   input  logic            rst_n,
   input  logic            flush,
   input  logic            in_valid,
   output logic            in_ready,
   input  logic [31:0]     in_instr,
   input  logic [PCW-1:0]  in_pc,
   output logic            out_valid,
   input  logic            out_ready,
   output logic [XLEN-1:0] out_pc,
   output logic [6:0]      out_opcode,
   output logic [2:0]      out_func3,
   output logic            out_func7,
   output logic [4:0]      out_rs1,
   output logic [4:0]      out_rs2,
   output logic [4:0]      out_rd,
   output logic [XLEN-1:0] out_imm,
   output logic [1:0]      out_v1type,
   output logic [1:0]      out_v2type,
   output logic            out_mul_en,
   output logic [1:0]      out_mem_mode,
   output logic [1:0]      out_jump_mode,
   output logic            out_pred_taken,
   output logic            out_illegal,
   output logic            redir_valid,
   output logic [XLEN-1:0] redir_pc
);

   dec_t            dec;
   logic            cand;
   logic            accept;
   logic [XLEN-1:0] pc_x;

   dec_t            out_q,  skid_q;
   logic [XLEN-1:0] out_pc_q, skid_pc_q;
   logic            out_pred_q, skid_pred_q;
   logic            out_valid_q, skid_valid;
   logic            redir_valid_q;
   logic [XLEN-1:0] redir_pc_q;

   ysyx_22041412_idu_dec #(.PREDICT_B(PREDICT_B)) u_dec (
      .instr      (in_instr),
      .dec        (dec),
      .redir_cand (cand)
   );

   assign pc_x     = XLEN'(in_pc);
   assign in_ready = rst_n & ~skid_valid;
   assign accept   = in_valid & in_ready & ~flush;

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         // NOTE: payload registers are reset too, so every out_* reads 0 after reset.
         out_valid_q   <= 1'b0;
         out_q         <= '0;
         out_pc_q      <= '0;
         out_pred_q    <= 1'b0;
         skid_valid    <= 1'b0;
         skid_q        <= '0;
         skid_pc_q     <= '0;
         skid_pred_q   <= 1'b0;
         redir_valid_q <= 1'b0;
         redir_pc_q    <= '0;
      end else if (flush) begin
         out_valid_q   <= 1'b0;
         skid_valid    <= 1'b0;
         redir_valid_q <= 1'b0;
      end else begin
         // NOTE: non-blocking assignments keep every register update on the old state.
         redir_valid_q <= accept & cand;
         if (accept && cand) redir_pc_q <= pc_x + dec.imm[XLEN-1:0];

         if (!out_valid_q || out_ready) begin
            // Skid entry is older than anything on the input, so it drains first.
            if (skid_valid) begin
               out_valid_q <= 1'b1;
               out_q       <= skid_q;
               out_pc_q    <= skid_pc_q;
               out_pred_q  <= skid_pred_q;
               skid_valid  <= 1'b0;
            end else if (accept) begin
               out_valid_q <= 1'b1;
               out_q       <= dec;
               out_pc_q    <= pc_x;
               out_pred_q  <= cand;
            end else begin
               out_valid_q <= 1'b0;
            end
         end else if (accept) begin
            skid_valid  <= 1'b1;
            skid_q      <= dec;
            skid_pc_q   <= pc_x;
            skid_pred_q <= cand;
         end
      end
   end

   assign out_valid      = out_valid_q;
   assign out_pc         = out_pc_q;
   assign out_opcode     = out_q.opcode;
   assign out_func3      = out_q.func3;
   assign out_func7      = out_q.func7;
   assign out_rs1        = out_q.rs1;
   assign out_rs2        = out_q.rs2;
   assign out_rd         = out_q.rd;
   assign out_imm        = out_q.imm[XLEN-1:0];
   assign out_v1type     = out_q.v1type;
   assign out_v2type     = out_q.v2type;
   assign out_mul_en     = out_q.mul_en;
   assign out_mem_mode   = out_q.mem_mode;
   assign out_jump_mode  = out_q.jump_mode;
   assign out_pred_taken = out_pred_q;
   assign out_illegal    = out_q.illegal;
   assign redir_valid    = redir_valid_q;
   assign redir_pc       = redir_pc_q;

endmodule
